out_arbiter: RTL and testbench

OUT_ARBITER -- requirements
Module: out_arbiter

---
 rtl/out_arbiter.sv | 127 ++++++++++++
 tb/tb_out_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_arbiter.sv
// out_arbiter: round-robin arbiter that forwards whole packets from NPORT
// input FIFOs into one downstream FIFO. The grant is locked for the duration
// of a packet and is released only by a tail or single flit.
module out_arbiter #(
    parameter int NPORT    = 4,
    parameter int PORTW    = 2,
    parameter int DATASIZE = 30
) (
    input  logic                      fifo_clk,
    input  logic                      rst,
    input  logic [NPORT-1:0]          in_empty_n,
    input  logic [NPORT*DATASIZE-1:0] in_data,
    output logic [NPORT-1:0]          in_rd_en,
    input  logic                      out_full,
    output logic [DATASIZE-1:0]       out_data,
    output logic                      out_valid,
    output logic [PORTW-1:0]          grant,
    output logic                      busy,
    output logic                      proto_err,
    output logic [15:0]               pkt_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    state_t               state;
    logic [PORTW-1:0]     rr_ptr;
    logic                 first_flit;

    logic [PORTW-1:0]     winner;
    logic                 any_req;
    logic                 pop;
    logic [DATASIZE-1:0]  cur_flit;
    logic [1:0]           cur_type;
    logic                 bad_start;
    logic                 ends_pkt;
    logic [PORTW-1:0]     next_ptr;

    // Round-robin search: walk from the farthest candidate back to rr_ptr so the nearest requester wins.
    always_comb begin
        int               idx;
        logic [PORTW-1:0] idx_p;
        idx     = 0;
        idx_p   = '0;
        winner  = rr_ptr;
        any_req = |in_empty_n;
        for (int i = NPORT - 1; i >= 0; i--) begin
            idx   = (int'(rr_ptr) + i) % NPORT;
            idx_p = PORTW'(idx);
            if (in_empty_n[idx_p]) begin
                winner = idx_p;
            end
        end
    end

    // Select the head flit of the granted FIFO and classify it.
    always_comb begin
        cur_flit = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (grant == PORTW'(p)) begin
                cur_flit = in_data[p*DATASIZE +: DATASIZE];
            end
        end
        cur_type  = cur_flit[DATASIZE-1 -: 2];
        bad_start = first_flit && ((cur_type == TYPE_BODY) || (cur_type == TYPE_TAIL));
        ends_pkt  = (cur_type == TYPE_TAIL) || (cur_type == TYPE_SINGLE);
        next_ptr  = (grant == PORTW'(NPORT - 1)) ? '0 : grant + 1'b1;
    end

    // Pop strobe: only the granted port, only while data is present and downstream has room.
    always_comb begin
        pop      = !rst && (state == XFER) && in_empty_n[grant] && !out_full;
        in_rd_en = pop ? (NPORT'(1) << grant) : '0;
    end

    assign busy = (state == XFER);

    // Packet FSM: arbitrate in IDLE, forward flits in XFER until the packet closes or starts badly.
    always_ff @(posedge fifo_clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            first_flit <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            proto_err  <= 1'b0;
            pkt_cnt    <= '0;
        end else begin
            out_valid <= 1'b0;
            proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= winner;
                        first_flit <= 1'b1;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (pop) begin
                        if (bad_start) begin
                            proto_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_data   <= cur_flit;
                            out_valid  <= 1'b1;
                            first_flit <= 1'b0;
                            if (ends_pkt) begin
                                state   <= IDLE;
                                rr_ptr  <= next_ptr;
                                pkt_cnt <= pkt_cnt + 16'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_arbiter.sv
// tb_out_arbiter: drives out_arbiter from queue-based FIFO models and checks
// every cycle against a packet-level reference model, plus directed scenarios
// with hand-computed expectations.
module tb_out_arbiter;

    localparam int NPORT = 4;
    localparam int PORTW = 2;
    localparam int DW    = 30;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic                   fifo_clk = 1'b0;
    logic                   rst;
    logic [NPORT-1:0]       in_empty_n;
    logic [NPORT*DW-1:0]    in_data;
    logic [NPORT-1:0]       in_rd_en;
    logic                   out_full;
    logic [DW-1:0]          out_data;
    logic                   out_valid;
    logic [PORTW-1:0]       grant;
    logic                   busy;
    logic                   proto_err;
    logic [15:0]            pkt_cnt;

    always #5 fifo_clk = ~fifo_clk;

    out_arbiter #(.NPORT(NPORT), .PORTW(PORTW), .DATASIZE(DW)) dut (
        .fifo_clk   (fifo_clk),
        .rst        (rst),
        .in_empty_n (in_empty_n),
        .in_data    (in_data),
        .in_rd_en   (in_rd_en),
        .out_full   (out_full),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .grant      (grant),
        .busy       (busy),
        .proto_err  (proto_err),
        .pkt_cnt    (pkt_cnt)
    );

    // source FIFOs and pending stimulus
    logic [DW-1:0]    fifo_q [NPORT][$];
    logic             nxt_rst;
    logic             nxt_full;
    logic [NPORT-1:0] pend_pop;

    // reference model state and expected registered outputs
    bit               started;
    bit               m_xfer;
    bit               m_first;
    int               m_grant;
    int               m_ptr;
    logic [15:0]      m_cnt;
    logic [DW-1:0]    e_data;
    logic             e_valid;
    logic             e_perr;
    logic [NPORT-1:0] m_rd;

    // observation logs
    logic [DW-1:0]    log_data [$];
    int               log_grant [$];
    int               log_cyc [$];
    int               perr_count;
    int               stall_viol;
    int               cyc;
    logic             obs_valid;
    logic             obs_busy;
    logic [PORTW-1:0] obs_grant;
    logic [15:0]      obs_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [27:0] pl);
        return {t, pl};
    endfunction

    function automatic logic [31:0] logDataAt(input int i);
        if (i < log_data.size()) return 32'(log_data[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] logGrantAt(input int i);
        if (i < log_grant.size()) return 32'(log_grant[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] logCycAt(input int i);
        if (i < log_cyc.size()) return 32'(log_cyc[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic checkOne(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // compare registered outputs with the model and record what was forwarded
    task automatic checkOutput();
        checkOne("out_valid", 32'(out_valid), 32'(e_valid));
        checkOne("out_data",  32'(out_data),  32'(e_data));
        checkOne("grant",     32'(grant),     32'(m_grant));
        checkOne("busy",      32'(busy),      32'(m_xfer));
        checkOne("proto_err", 32'(proto_err), 32'(e_perr));
        checkOne("pkt_cnt",   32'(pkt_cnt),   32'(m_cnt));
        obs_valid = out_valid;
        obs_busy  = busy;
        obs_grant = grant;
        obs_cnt   = pkt_cnt;
        if (out_valid === 1'b1) begin
            log_data.push_back(out_data);
            log_grant.push_back(int'(grant));
            log_cyc.push_back(cyc);
        end
        if (proto_err === 1'b1) perr_count++;
    endtask

    // retire last cycle's pops and present FIFO heads, reset and full to the DUT
    task automatic applyStimulus();
        for (int p = 0; p < NPORT; p++) begin
            if (pend_pop[p] && fifo_q[p].size() > 0) void'(fifo_q[p].pop_front());
        end
        pend_pop = '0;
        rst      = nxt_rst;
        out_full = nxt_full;
        for (int p = 0; p < NPORT; p++) begin
            in_empty_n[p]         = (fifo_q[p].size() > 0);
            in_data[p*DW +: DW]   = (fifo_q[p].size() > 0) ? fifo_q[p][0] : '0;
        end
    endtask

    // packet-level reference: decide what the coming clock edge does
    task automatic modelStep();
        logic [DW-1:0] f;
        logic [1:0]    t;
        m_rd    = '0;
        started = 1'b1;
        if (rst) begin
            m_xfer  = 0;
            m_first = 0;
            m_ptr   = 0;
            m_grant = 0;
            m_cnt   = '0;
            e_data  = '0;
            e_valid = 1'b0;
            e_perr  = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_perr  = 1'b0;
            if (!m_xfer) begin
                for (int i = 0; i < NPORT; i++) begin
                    int p;
                    p = (m_ptr + i) % NPORT;
                    if (fifo_q[p].size() > 0) begin
                        m_grant = p;
                        m_xfer  = 1;
                        m_first = 1;
                        break;
                    end
                end
            end else if (fifo_q[m_grant].size() > 0 && !out_full) begin
                m_rd[m_grant] = 1'b1;
                f = fifo_q[m_grant][0];
                t = f[DW-1 -: 2];
                if (m_first && (t == T_BODY || t == T_TAIL)) begin
                    e_perr = 1'b1;
                    m_xfer = 0;
                end else begin
                    e_data  = f;
                    e_valid = 1'b1;
                    m_first = 0;
                    if (t == T_TAIL || t == T_SINGLE) begin
                        m_xfer = 0;
                        m_ptr  = (m_grant + 1) % NPORT;
                        m_cnt  = m_cnt + 16'd1;
                    end
                end
            end
        end
        pend_pop = m_rd;
    endtask

    // one clock cycle: check at the falling edge, drive, predict, then let the edge happen
    task automatic tick();
        @(negedge fifo_clk);
        cyc++;
        if (started) checkOutput();
        applyStimulus();
        #1;
        modelStep();
        checkOne("in_rd_en", 32'(in_rd_en), 32'(m_rd));
        if (out_full && in_rd_en !== '0) stall_viol++;
        @(posedge fifo_clk);
    endtask

    task automatic clearLogs();
        log_data.delete();
        log_grant.delete();
        log_cyc.delete();
        perr_count = 0;
        stall_viol = 0;
    endtask

    task automatic resetDut();
        nxt_rst = 1'b1;
        tick();
        nxt_rst = 1'b0;
        clearLogs();
    endtask

    task automatic randomPush();
        int kind;
        int nb;
        for (int p = 0; p < NPORT; p++) begin
            if ($urandom_range(0, 7) == 0 && fifo_q[p].size() < 12) begin
                kind = $urandom_range(0, 9);
                if (kind == 0) begin
                    fifo_q[p].push_back(mk($urandom_range(0, 1) ? T_BODY : T_TAIL, 28'($urandom)));
                end else if (kind <= 3) begin
                    fifo_q[p].push_back(mk(T_SINGLE, 28'($urandom)));
                end else begin
                    nb = $urandom_range(0, 3);
                    fifo_q[p].push_back(mk(T_HEAD, 28'($urandom)));
                    for (int b = 0; b < nb; b++)
                        fifo_q[p].push_back(mk(($urandom_range(0, 4) == 0) ? T_HEAD : T_BODY, 28'($urandom)));
                    fifo_q[p].push_back(mk(T_TAIL, 28'($urandom)));
                end
            end
        end
    endtask

    initial begin
        int push_cyc;
        int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

        rst        = 1'b1;
        out_full   = 1'b0;
        in_empty_n = '0;
        in_data    = '0;
        nxt_rst    = 1'b1;
        nxt_full   = 1'b0;
        pend_pop   = '0;
        cyc        = 0;
        started    = 1'b0;
        clearLogs();
        tick();
        resetDut();

        // single port, three-flit packet, then next arbitration starts after port 0
        fifo_q[0].push_back(mk(T_HEAD, 28'h1));
        fifo_q[0].push_back(mk(T_BODY, 28'h2));
        fifo_q[0].push_back(mk(T_TAIL, 28'h3));
        push_cyc = cyc;
        repeat (10) tick();
        checkOne("s1_count",   32'(log_data.size()), 32'd3);
        checkOne("s1_flit0",   logDataAt(0), 32'h1000_0001);
        checkOne("s1_flit1",   logDataAt(1), 32'h0000_0002);
        checkOne("s1_flit2",   logDataAt(2), 32'h2000_0003);
        checkOne("s1_latency", logCycAt(0) - 32'(push_cyc), 32'd3);
        checkOne("s1_contig",  logCycAt(2) - logCycAt(0), 32'd2);
        checkOne("s1_pkt_cnt", 32'(obs_cnt), 32'd1);
        fifo_q[0].push_back(mk(T_SINGLE, 28'h70));
        fifo_q[1].push_back(mk(T_SINGLE, 28'h71));
        repeat (8) tick();
        checkOne("s1_rr_next", logGrantAt(3), 32'd1);
        checkOne("s1_rr_wrap", logGrantAt(4), 32'd0);

        // fairness: two singles per port
        resetDut();
        for (int p = 0; p < NPORT; p++)
            for (int k = 0; k < 2; k++)
                fifo_q[p].push_back(mk(T_SINGLE, 28'(p * 16 + k)));
        repeat (30) tick();
        for (int i = 0; i < 8; i++) checkOne("s2_order", logGrantAt(i), 32'(exp_order[i]));
        checkOne("s2_pkt_cnt", 32'(obs_cnt), 32'd8);

        // lock: port 1 shows up while port 2 is mid-packet
        resetDut();
        fifo_q[2].push_back(mk(T_HEAD, 28'h200));
        fifo_q[2].push_back(mk(T_BODY, 28'h201));
        fifo_q[2].push_back(mk(T_BODY, 28'h202));
        fifo_q[2].push_back(mk(T_TAIL, 28'h203));
        repeat (3) tick();
        fifo_q[1].push_back(mk(T_SINGLE, 28'h100));
        repeat (20) tick();
        for (int i = 0; i < 4; i++) begin
            checkOne("s3_lock_grant", logGrantAt(i), 32'd2);
            checkOne("s3_lock_data",  logDataAt(i),  32'h0000_0200 + 32'(i) + ((i == 0) ? 32'h1000_0000 : (i == 3) ? 32'h2000_0000 : 32'h0));
        end
        checkOne("s3_contig",   logCycAt(3) - logCycAt(0), 32'd3);
        checkOne("s3_after",    logGrantAt(4), 32'd1);
        checkOne("s3_after_dt", logDataAt(4),  32'h3000_0100);

        // backpressure for five cycles in the middle of a packet
        resetDut();
        fifo_q[0].push_back(mk(T_HEAD, 28'h10));
        fifo_q[0].push_back(mk(T_BODY, 28'h11));
        fifo_q[0].push_back(mk(T_BODY, 28'h12));
        fifo_q[0].push_back(mk(T_BODY, 28'h13));
        fifo_q[0].push_back(mk(T_TAIL, 28'h14));
        for (int k = 0; k < 10 && log_data.size() < 2; k++) tick();
        nxt_full   = 1'b1;
        stall_viol = 0;
        repeat (5) tick();
        nxt_full = 1'b0;
        repeat (10) tick();
        checkOne("s4_stall_rd", 32'(stall_viol), 32'd0);
        checkOne("s4_count",    32'(log_data.size()), 32'd5);
        checkOne("s4_flit0",    logDataAt(0), 32'h1000_0010);
        checkOne("s4_flit1",    logDataAt(1), 32'h0000_0011);
        checkOne("s4_flit2",    logDataAt(2), 32'h0000_0012);
        checkOne("s4_flit3",    logDataAt(3), 32'h0000_0013);
        checkOne("s4_flit4",    logDataAt(4), 32'h2000_0014);

        // protocol error: stray body flit on port 3
        resetDut();
        fifo_q[3].push_back(mk(T_BODY, 28'h55));
        repeat (6) tick();
        checkOne("s5_perr",    32'(perr_count), 32'd1);
        checkOne("s5_novalid", 32'(log_data.size()), 32'd0);
        checkOne("s5_pkt_cnt", 32'(obs_cnt), 32'd0);
        checkOne("s5_idle",    32'(obs_busy), 32'd0);

        // reset after the second flit of a three-flit packet
        resetDut();
        fifo_q[1].push_back(mk(T_HEAD, 28'h30));
        fifo_q[1].push_back(mk(T_BODY, 28'h31));
        fifo_q[1].push_back(mk(T_TAIL, 28'h32));
        for (int k = 0; k < 10 && log_data.size() < 1; k++) tick();
        nxt_rst = 1'b1;
        tick();
        nxt_rst = 1'b0;
        tick();
        checkOne("s6_rst_valid", 32'(obs_valid), 32'd0);
        checkOne("s6_rst_grant", 32'(obs_grant), 32'd0);
        checkOne("s6_rst_busy",  32'(obs_busy),  32'd0);
        checkOne("s6_rst_cnt",   32'(obs_cnt),   32'd0);
        repeat (8) tick();
        checkOne("s6_count", 32'(log_data.size()), 32'd2);
        checkOne("s6_flit1", logDataAt(1), 32'h0000_0031);
        checkOne("s6_perr",  32'(perr_count), 32'd1);

        // randomized traffic with stalls and occasional resets
        resetDut();
        for (int n = 0; n < 2500; n++) begin
            randomPush();
            nxt_full = ($urandom_range(0, 3) == 0);
            nxt_rst  = ($urandom_range(0, 299) == 0);
            tick();
        end
        nxt_full = 1'b0;
        nxt_rst  = 1'b0;
        repeat (100) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
